// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Collects a byte stream over valid/ready, packs bytes little-endian into
// 32-bit words, writes them to consecutive word addresses and releases the
// CPU (start_o) once the whole image has landed in memory.
module imem_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    input  logic             byte_last_i,
    output logic             byte_ready_o,
    output logic             wr_en_o,
    output logic [31:0]      wr_addr_o,
    output logic [31:0]      wr_data_o,
    output logic             start_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] word_count_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERR     = 3'd4;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [1:0]       lane;
    logic [31:0]      asm_word;
    logic [CNT_W-1:0] word_count;
    logic             last_seen;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;

    logic             accepting;
    logic             transfer;
    logic             overflow;
    logic             word_done;
    logic [31:0]      merged;
    logic [31:0]      next_addr;
    logic [31:0]      count_ext;

    // Handshake and word-completion decode; ready depends on state only.
    always_comb begin
        accepting = (state == S_IDLE) || (state == S_COLLECT);
        transfer  = byte_valid_i && accepting;
        // A new word would start while memory is already full.
        overflow  = transfer && (lane == 2'd0) && (word_count == DEPTH_C);
        word_done = transfer && !overflow && ((lane == 2'd3) || byte_last_i);
        // Upper lanes are zero because the assembly register is cleared
        // after every write, so a short final word comes out zero-padded.
        merged    = asm_word | ({24'd0, byte_data_i} << {lane, 3'b000});
        count_ext = {{(32-CNT_W){1'b0}}, word_count};
        next_addr = BASE_ADDR + (count_ext << 2);
    end

    // Next-state logic for the load sequence.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_COLLECT: begin
                if (overflow) begin
                    state_next = S_ERR;
                end else if (word_done) begin
                    state_next = S_WRITE;
                end else if (transfer) begin
                    state_next = S_COLLECT;
                end
            end
            S_WRITE: begin
                state_next = last_seen ? S_DONE : S_COLLECT;
            end
            S_DONE:  state_next = S_DONE;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Byte packing, word counter and the held write address/data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lane       <= 2'd0;
            asm_word   <= 32'd0;
            word_count <= '0;
            last_seen  <= 1'b0;
            wr_addr    <= 32'd0;
            wr_data    <= 32'd0;
        end else begin
            if (transfer && !overflow) begin
                asm_word <= merged;
                lane     <= lane + 2'd1;
                if (word_done) begin
                    wr_data   <= merged;
                    wr_addr   <= next_addr;
                    last_seen <= byte_last_i;
                end
            end
            if (state == S_WRITE) begin
                word_count <= word_count + 1'b1;
                lane       <= 2'd0;
                asm_word   <= 32'd0;
            end
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        byte_ready_o = accepting;
        wr_en_o      = (state == S_WRITE);
        wr_addr_o    = wr_addr;
        wr_data_o    = wr_data;
        start_o      = (state == S_DONE);
        busy_o       = (state == S_COLLECT) || (state == S_WRITE);
        err_o        = (state == S_ERR);
        word_count_o = word_count;
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader.
// Instance u_a uses default parameters (BASE 0, DEPTH 256); instance u_b uses
// BASE 0x100 and DEPTH 2. Both share the same input stream.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic       last;

    logic        a_ready, a_wr_en, a_start, a_busy, a_err;
    logic [31:0] a_addr, a_data;
    logic [8:0]  a_count;
    logic        b_ready, b_wr_en, b_start, b_busy, b_err;
    logic [31:0] b_addr, b_data;
    logic [8:0]  b_count;

    int n_chk = 0;
    int n_err = 0;
    int a_writes = 0;
    int b_writes = 0;
    int snap;

    imem_loader u_a (
        .clk_i(clk), .rst_i(rst_n), .byte_valid_i(valid), .byte_data_i(data),
        .byte_last_i(last), .byte_ready_o(a_ready), .wr_en_o(a_wr_en),
        .wr_addr_o(a_addr), .wr_data_o(a_data), .start_o(a_start),
        .busy_o(a_busy), .err_o(a_err), .word_count_o(a_count)
    );

    imem_loader #(.DEPTH(2), .BASE_ADDR(32'h0000_0100), .CNT_W(9)) u_b (
        .clk_i(clk), .rst_i(rst_n), .byte_valid_i(valid), .byte_data_i(data),
        .byte_last_i(last), .byte_ready_o(b_ready), .wr_en_o(b_wr_en),
        .wr_addr_o(b_addr), .wr_data_o(b_data), .start_o(b_start),
        .busy_o(b_busy), .err_o(b_err), .word_count_o(b_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_wr_en) a_writes <= a_writes + 1;
        if (b_wr_en) b_writes <= b_writes + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        valid = 1'b1;
        data  = d;
        last  = l;
        tick();
    endtask

    task automatic do_reset();
        valid = 1'b0;
        last  = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        last  = 1'b0;

        // Reset held with valid toggling
        for (int i = 0; i < 4; i++) begin
            valid = ~valid;
            data  = 8'hC0 + 8'(i);
            tick();
            chk("rst_ready", 32'(a_ready), 32'd1);
            chk("rst_wr_en", 32'(a_wr_en), 32'd0);
        end
        chk("rst_start", 32'(a_start), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_addr", a_addr, 32'd0);
        chk("rst_data", a_data, 32'd0);
        valid = 1'b0;
        rst_n = 1'b1;

        // Single word 13,00,00,00 with last on the 4th byte
        tick();
        send(8'h13, 1'b0);
        chk("sw_busy", 32'(a_busy), 32'd1);
        chk("sw_ready", 32'(a_ready), 32'd1);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b1);
        chk("sw_wr_en", 32'(a_wr_en), 32'd1);
        chk("sw_addr", a_addr, 32'h0000_0000);
        chk("sw_data", a_data, 32'h0000_0013);
        chk("sw_ready_wr", 32'(a_ready), 32'd0);
        chk("sw_start_early", 32'(a_start), 32'd0);
        valid = 1'b0;
        last  = 1'b0;
        tick();
        chk("sw_wr_en_off", 32'(a_wr_en), 32'd0);
        chk("sw_start", 32'(a_start), 32'd1);
        chk("sw_busy_done", 32'(a_busy), 32'd0);
        chk("sw_count", 32'(a_count), 32'd1);
        chk("sw_data_hold", a_data, 32'h0000_0013);
        tick();
        chk("sw_start_held", 32'(a_start), 32'd1);
        chk("sw_ready_done", 32'(a_ready), 32'd0);

        // Back-to-back words on BASE 0x100, exactly DEPTH=2 words
        do_reset();
        snap = b_writes;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        chk("bb_wr_en0", 32'(b_wr_en), 32'd1);
        chk("bb_addr0", b_addr, 32'h0000_0100);
        chk("bb_data0", b_data, 32'h0403_0201);
        chk("bb_ready_wr0", 32'(b_ready), 32'd0);
        send(8'h05, 1'b0);
        chk("bb_wr_en_gap", 32'(b_wr_en), 32'd0);
        chk("bb_count1", 32'(b_count), 32'd1);
        chk("bb_ready_col", 32'(b_ready), 32'd1);
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
        send(8'h08, 1'b1);
        chk("bb_wr_en1", 32'(b_wr_en), 32'd1);
        chk("bb_addr1", b_addr, 32'h0000_0104);
        chk("bb_data1", b_data, 32'h0807_0605);
        chk("bb_ready_wr1", 32'(b_ready), 32'd0);
        chk("bb_start_c9", 32'(b_start), 32'd0);
        valid = 1'b0;
        last  = 1'b0;
        tick();
        chk("bb_start_c10", 32'(b_start), 32'd1);
        chk("bb_err", 32'(b_err), 32'd0);
        chk("bb_count2", 32'(b_count), 32'd2);
        chk("bb_addr_hold", b_addr, 32'h0000_0104);
        chk("bb_writes", 32'(b_writes - snap), 32'd2);

        // Partial word AA,BB with three idle cycles between
        do_reset();
        send(8'hAA, 1'b0);
        valid = 1'b0;
        data  = 8'hEE;
        last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pw_gap_wr_en", 32'(a_wr_en), 32'd0);
            chk("pw_gap_busy", 32'(a_busy), 32'd1);
        end
        send(8'hBB, 1'b1);
        chk("pw_wr_en", 32'(a_wr_en), 32'd1);
        chk("pw_addr", a_addr, 32'h0000_0000);
        chk("pw_data", a_data, 32'h0000_BBAA);
        valid = 1'b0;
        last  = 1'b0;
        tick();
        chk("pw_start", 32'(a_start), 32'd1);
        chk("pw_count", 32'(a_count), 32'd1);

        // Last byte on lane 0
        do_reset();
        send(8'h7F, 1'b1);
        chk("l0_wr_en", 32'(a_wr_en), 32'd1);
        chk("l0_data", a_data, 32'h0000_007F);
        valid = 1'b0;
        last  = 1'b0;
        tick();
        chk("l0_start", 32'(a_start), 32'd1);

        // Overflow on DEPTH=2: continuous bytes, no last
        do_reset();
        snap = b_writes;
        for (int i = 0; i < 10; i++) send(8'h5A, 1'b0);
        chk("ov_err_pre", 32'(b_err), 32'd0);
        chk("ov_count", 32'(b_count), 32'd2);
        chk("ov_ready_pre", 32'(b_ready), 32'd1);
        send(8'h5A, 1'b0);
        chk("ov_err", 32'(b_err), 32'd1);
        chk("ov_start", 32'(b_start), 32'd0);
        chk("ov_ready", 32'(b_ready), 32'd0);
        chk("ov_wr_en", 32'(b_wr_en), 32'd0);
        for (int i = 0; i < 3; i++) send(8'h5A, 1'b0);
        chk("ov_err_sticky", 32'(b_err), 32'd1);
        chk("ov_writes", 32'(b_writes - snap), 32'd2);
        valid = 1'b0;

        // Reset mid-load, then a fresh image
        do_reset();
        snap = a_writes;
        send(8'hDE, 1'b0);
        send(8'hAD, 1'b0);
        chk("rm_busy_pre", 32'(a_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_ready", 32'(a_ready), 32'd1);
        chk("rm_busy", 32'(a_busy), 32'd0);
        chk("rm_wr_en", 32'(a_wr_en), 32'd0);
        chk("rm_count", 32'(a_count), 32'd0);
        valid = 1'b0;
        tick();
        tick();
        chk("rm_no_write", 32'(a_writes - snap), 32'd0);
        rst_n = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        chk("rm_wr_en", 32'(a_wr_en), 32'd1);
        chk("rm_addr", a_addr, 32'h0000_0000);
        chk("rm_data", a_data, 32'h4433_2211);
        valid = 1'b0;
        last  = 1'b0;
        tick();
        chk("rm_start", 32'(a_start), 32'd1);
        chk("rm_writes", 32'(a_writes - snap), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
